game_speed_ctrl: RTL and testbench
==================================

Name: game_speed_ctrl

Overview:
- Parametrised successor to the game clock generator: produces the game-step enable pulse, raises difficulty in levels, and supplies the minimum obstacle gap for the obstacle spawner.
- Emits a one-cycle `tick` enable, not a divided clock. The game logic stays on `clk`.
- Sits between the top level and the scroller/obstacle/score blocks. Adds start, pause and clear control, level progression, and saturating speed and gap schedules.

Parameters:
- PERIOD_W, 24: width of the period and down-counter registers.
- PERIOD_INIT, 500000: clocks per tick at level 0.
- PERIOD_MIN, 100000: floor for the tick period.
- PERIOD_STEP, 20000: period decrement per level.
- TICKS_PER_LEVEL, 1000: ticks per level-up.
- LVL_W, 5: level width.
- MAX_LEVEL, 20: saturating level.
- GAP_W, 9: min_empty width.
- GAP_BASE, 120: min_empty at level 0.
- GAP_STEP, 8: min_empty increment per level.
- GAP_MAX, 400: min_empty ceiling.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset.
- start, in, 1: begin run. Sampled in IDLE only.
- pause, in, 1: level-sensitive hold.
- clear, in, 1: synchronous game restart.
- tick, out, 1: one-cycle game-step enable.
- level, out, LVL_W: current level.
- period, out, PERIOD_W: current tick period in clocks.
- min_empty, out, GAP_W: minimum obstacle gap for the current level.
- running, out, 1: high in RUN.
- max_level, out, 1: high when level == MAX_LEVEL.

Behaviour:
- Clock and reset: one clock (`clk`). `rst` is asynchronous, active-high.
- Reset values: state = IDLE, tick = 0, level = 0, period = PERIOD_INIT, min_empty = GAP_BASE, running = 0, max_level = 0, down-counter = PERIOD_INIT-1, tick counter = 0.
- FSM states: IDLE, RUN, HOLD. All outputs are registered.
- Input priority: clear > pause > start.
  - clear in any state: next edge forces all registers to their reset values (IDLE). A start asserted in the same cycle is ignored.
  - IDLE: start = 1 → RUN. pause in IDLE is ignored.
  - RUN: pause = 1 → HOLD. start is ignored.
  - HOLD: pause = 0 → RUN. The counter is frozen in HOLD and resumes from its held value.
- Tick generation:
  - In RUN, each edge: if down-counter == 0, assert tick for one cycle and reload the counter with (new period - 1); otherwise decrement.
  - First tick rises at the PERIOD_INIT-th edge after the edge that enters RUN. Thereafter ticks are exactly `period` clocks apart.
  - No tick in IDLE or HOLD. A pause lasting N cycles delays the next tick by exactly N cycles.
- Level-up:
  - On each tick, the tick counter increments.
  - On the tick that brings it to TICKS_PER_LEVEL, the tick counter resets to 0. If level < MAX_LEVEL, on that same edge:
    - level increments;
    - period becomes PERIOD_MIN if period < PERIOD_MIN + PERIOD_STEP, else period - PERIOD_STEP (compare before subtracting; no underflow);
    - min_empty becomes min(GAP_BASE + level_new*GAP_STEP, GAP_MAX), computed at GAP_W+LVL_W bits, then saturated.
  - The reload on that tick already uses the new period.
  - At MAX_LEVEL: the tick counter still wraps, but level, period and min_empty hold. max_level = 1.
- rst mid-run: outputs take reset values immediately, without waiting for a clock edge. tick drops the same cycle.

Test Plan:
Use PERIOD_INIT=10, PERIOD_MIN=4, PERIOD_STEP=3, TICKS_PER_LEVEL=2, MAX_LEVEL=3, GAP_BASE=5, GAP_STEP=2, GAP_MAX=9.
1. Reset, then 50 clocks with no start → tick never asserted; level=0, period=10, min_empty=5, running=0.
2. One-cycle start pulse at edge 0 → ticks at edges 10, 20, 27, 34, 38, 42, 46…
   - level 1 at edge 20 (period 7, min_empty 7);
   - level 2 at edge 34 (period 4, min_empty 9);
   - level 3 at edge 42 (period 4, min_empty 9 capped, max_level=1).
   - Level, period and min_empty unchanged at edge 46 and later.
3. In RUN at level 0, pause high for 5 cycles starting 3 clocks after a tick → no tick during HOLD; next tick 15 clocks after the previous one; running=0 during HOLD.
4. clear asserted at level 2 → next edge: level=0, period=10, min_empty=5, max_level=0, running=0, ticks stop. A new start reproduces scenario 2 timing exactly.
5. Assert rst between clock edges while tick=1 at level 2 → all outputs at reset values before the next edge.
6. Same-cycle events:
   - start+clear in IDLE → stays IDLE;
   - pause+clear in RUN → IDLE;
   - start while RUN → no effect on tick phase;
   - pause in IDLE → stays IDLE.

Source files
------------

// File: rtl/game_speed_ctrl.sv
// -----------------------------------------------------------------------------
// game_speed_ctrl
//
// Game pacing controller. Produces a one-cycle `tick` enable that steps the
// game logic (everything stays on `clk`). It also raises the difficulty level
// every TICKS_PER_LEVEL ticks, and it shortens the tick period and widens the
// minimum obstacle gap with each level. Both schedules saturate.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   start      begin a run (only honoured while idle)
//   pause      level-sensitive hold of the tick counter
//   clear      synchronous restart to the reset state (highest priority)
//   tick       one-cycle game-step enable
//   level      current difficulty level (saturates at MAX_LEVEL)
//   period     current tick period in clocks
//   min_empty  minimum obstacle gap for the current level
//   running    high while actively running (not idle, not held)
//   max_level  high once level == MAX_LEVEL
// -----------------------------------------------------------------------------
module game_speed_ctrl #(
    parameter int PERIOD_W        = 24,
    parameter int PERIOD_INIT     = 500000,
    parameter int PERIOD_MIN      = 100000,
    parameter int PERIOD_STEP     = 20000,
    parameter int TICKS_PER_LEVEL = 1000,
    parameter int LVL_W           = 5,
    parameter int MAX_LEVEL       = 20,
    parameter int GAP_W           = 9,
    parameter int GAP_BASE        = 120,
    parameter int GAP_STEP        = 8,
    parameter int GAP_MAX         = 400
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pause,
    input  logic                clear,
    output logic                tick,
    output logic [LVL_W-1:0]    level,
    output logic [PERIOD_W-1:0] period,
    output logic [GAP_W-1:0]    min_empty,
    output logic                running,
    output logic                max_level
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int TC_W  = $clog2(TICKS_PER_LEVEL + 1);
    // The gap schedule is evaluated wide enough that base + level*step cannot
    // wrap before it is compared against the ceiling.
    localparam int SUM_W = GAP_W + LVL_W;

    localparam logic [PERIOD_W-1:0] P_INIT    = PERIOD_W'(PERIOD_INIT);
    localparam logic [PERIOD_W-1:0] P_RELOAD0 = PERIOD_W'(PERIOD_INIT - 1);
    localparam logic [PERIOD_W-1:0] P_MIN     = PERIOD_W'(PERIOD_MIN);
    localparam logic [PERIOD_W-1:0] P_STEP    = PERIOD_W'(PERIOD_STEP);
    localparam logic [PERIOD_W-1:0] P_KNEE    = PERIOD_W'(PERIOD_MIN + PERIOD_STEP);
    localparam logic [PERIOD_W-1:0] P_ONE     = PERIOD_W'(1);
    localparam logic [TC_W-1:0]     TC_LAST   = TC_W'(TICKS_PER_LEVEL - 1);
    localparam logic [TC_W-1:0]     TC_ONE    = TC_W'(1);
    localparam logic [LVL_W-1:0]    L_MAX     = LVL_W'(MAX_LEVEL);
    localparam logic [LVL_W-1:0]    L_ONE     = LVL_W'(1);
    localparam logic [GAP_W-1:0]    G_BASE    = GAP_W'(GAP_BASE);
    localparam logic [GAP_W-1:0]    G_MAX     = GAP_W'(GAP_MAX);
    localparam logic [SUM_W-1:0]    G_BASE_W  = SUM_W'(GAP_BASE);
    localparam logic [SUM_W-1:0]    G_STEP_W  = SUM_W'(GAP_STEP);
    localparam logic [SUM_W-1:0]    G_MAX_W   = SUM_W'(GAP_MAX);

    state_t              state;
    logic [PERIOD_W-1:0] cnt;       // clocks remaining until the next tick
    logic [TC_W-1:0]     tick_cnt;  // ticks seen within the current level

    logic                advance;
    logic                fire;
    logic                wrap;
    logic                bump;
    logic [LVL_W-1:0]    level_nxt;
    logic [PERIOD_W-1:0] period_nxt;
    logic [PERIOD_W-1:0] reload;
    logic [SUM_W-1:0]    gap_sum;
    logic [GAP_W-1:0]    gap_nxt;

    // NOTE: every signal is assigned on every path through this block, so no
    // latch can be inferred.
    always_comb begin
        // The resume edge out of HOLD counts, so a pause of N edges delays the
        // next tick by exactly N clocks.
        advance    = (state != IDLE) && !pause;
        fire       = advance && (cnt == '0);
        wrap       = fire && (tick_cnt == TC_LAST);
        bump       = wrap && (level < L_MAX);
        level_nxt  = level + L_ONE;
        // Compare before subtracting so the period never underflows.
        period_nxt = (period < P_KNEE) ? P_MIN : period - P_STEP;
        gap_sum    = G_BASE_W + SUM_W'(level_nxt) * G_STEP_W;
        gap_nxt    = (gap_sum > G_MAX_W) ? G_MAX : gap_sum[GAP_W-1:0];
        // The reload on a level-up tick already uses the shortened period.
        reload     = (bump ? period_nxt : period) - P_ONE;
    end

    // NOTE: asynchronous reset lives in the sensitivity list and all state is
    // updated with non-blocking assignments so every register samples the
    // pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick      <= 1'b0;
            level     <= '0;
            period    <= P_INIT;
            min_empty <= G_BASE;
            running   <= 1'b0;
            max_level <= 1'b0;
            cnt       <= P_RELOAD0;
            tick_cnt  <= '0;
        end else if (clear) begin
            state     <= IDLE;
            tick      <= 1'b0;
            level     <= '0;
            period    <= P_INIT;
            min_empty <= G_BASE;
            running   <= 1'b0;
            max_level <= 1'b0;
            cnt       <= P_RELOAD0;
            tick_cnt  <= '0;
        end else begin
            tick <= fire;

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN, HOLD: begin
                    state   <= pause ? HOLD : RUN;
                    running <= !pause;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase

            if (advance) begin
                if (fire) begin
                    cnt      <= reload;
                    tick_cnt <= wrap ? '0 : tick_cnt + TC_ONE;
                    if (bump) begin
                        level     <= level_nxt;
                        period    <= period_nxt;
                        min_empty <= gap_nxt;
                        max_level <= (level_nxt == L_MAX);
                    end
                end else begin
                    cnt <= cnt - P_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_game_speed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_speed_ctrl
//
// Self-checking bench for game_speed_ctrl using small parameters. A reference
// model describes the game in terms of ticks issued so far: level, period and
// gap are closed-form functions of the tick count, and tick timing comes from
// counting active clocks since the previous tick.
// -----------------------------------------------------------------------------
module tb_game_speed_ctrl;

    localparam int PERIOD_W    = 24;
    localparam int PERIOD_INIT = 10;
    localparam int PERIOD_MIN  = 4;
    localparam int PERIOD_STEP = 3;
    localparam int TPL         = 2;
    localparam int LVL_W       = 5;
    localparam int MAX_LEVEL   = 3;
    localparam int GAP_W       = 9;
    localparam int GAP_BASE    = 5;
    localparam int GAP_STEP    = 2;
    localparam int GAP_MAX     = 9;

    localparam int OUT_W = 3 + LVL_W + PERIOD_W + GAP_W;
    localparam int CHK_W = 1 + LVL_W + PERIOD_W + GAP_W;

    localparam logic [OUT_W-1:0] RST_VEC =
        {1'b0, LVL_W'(0), PERIOD_W'(PERIOD_INIT), GAP_W'(GAP_BASE), 1'b0, 1'b0};

    logic                clk;
    logic                rst;
    logic                start;
    logic                pause;
    logic                clear;
    logic                tick;
    logic [LVL_W-1:0]    level;
    logic [PERIOD_W-1:0] period;
    logic [GAP_W-1:0]    min_empty;
    logic                running;
    logic                max_level;

    int n_cmp  = 0;
    int n_fail = 0;
    int ec     = 0;   // posedge counter

    game_speed_ctrl #(
        .PERIOD_W        (PERIOD_W),
        .PERIOD_INIT     (PERIOD_INIT),
        .PERIOD_MIN      (PERIOD_MIN),
        .PERIOD_STEP     (PERIOD_STEP),
        .TICKS_PER_LEVEL (TPL),
        .LVL_W           (LVL_W),
        .MAX_LEVEL       (MAX_LEVEL),
        .GAP_W           (GAP_W),
        .GAP_BASE        (GAP_BASE),
        .GAP_STEP        (GAP_STEP),
        .GAP_MAX         (GAP_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .tick      (tick),
        .level     (level),
        .period    (period),
        .min_empty (min_empty),
        .running   (running),
        .max_level (max_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_active;   // a run has been started
    bit m_run;      // actively running (not held)
    bit m_tick;
    int m_prog;     // active clocks since last tick (or since start)
    int m_ticks;    // ticks issued since start

    function automatic int m_level();
        int l;
        l = m_ticks / TPL;
        return (l > MAX_LEVEL) ? MAX_LEVEL : l;
    endfunction

    function automatic int m_period(input int l);
        int p;
        p = PERIOD_INIT - l * PERIOD_STEP;
        return (p < PERIOD_MIN) ? PERIOD_MIN : p;
    endfunction

    function automatic int m_gap(input int l);
        int g;
        g = GAP_BASE + l * GAP_STEP;
        return (g > GAP_MAX) ? GAP_MAX : g;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_run    = 0;
        m_tick   = 0;
        m_prog   = 0;
        m_ticks  = 0;
    endtask

    task automatic model_edge();
        m_tick = 0;
        if (clear) begin
            model_reset();
        end else if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_run    = 1;
                m_prog   = 0;
            end
        end else if (pause) begin
            m_run = 0;
        end else begin
            m_run  = 1;
            m_prog = m_prog + 1;
            if (m_prog == m_period(m_level())) begin
                m_tick  = 1;
                m_prog  = 0;
                m_ticks = m_ticks + 1;
            end
        end
    endtask

    function automatic logic [OUT_W-1:0] model_vec();
        int l;
        l = m_level();
        return {m_tick, LVL_W'(l), PERIOD_W'(m_period(l)), GAP_W'(m_gap(l)),
                m_run, (l == MAX_LEVEL) ? 1'b1 : 1'b0};
    endfunction

    function automatic logic [OUT_W-1:0] dut_vec();
        return {tick, level, period, min_empty, running, max_level};
    endfunction

    // One clock: inputs are sampled at the posedge, outputs read at the negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        ec = ec + 1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n_t;
        rst = 1; start = 0; pause = 0; clear = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want %h", dut_vec(), RST_VEC);
        end
        rst = 0;
        model_reset();
        n_t = 0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL reset_idle edge %0d: got %h want %h", ec, dut_vec(), model_vec());
            end
            if (tick) n_t++;
        end
        n_cmp++;
        if (n_t != 0) begin
            n_fail++;
            $display("FAIL idle_ticks: got %0d want 0", n_t);
        end
        n_cmp++;
        if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h want %h", dut_vec(), RST_VEC);
        end
    endtask

    // Starts a run from IDLE and checks the full level schedule over 50 edges.
    task automatic run_schedule(input string tag);
        int e0, rel;
        bit exp_t;
        logic [CHK_W-1:0] want;
        start = 1;
        cycle();
        start = 0;
        e0 = ec;
        n_cmp++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_start_running: got %b want 1", tag, running);
        end
        for (int i = 1; i <= 50; i++) begin
            cycle();
            rel   = ec - e0;
            exp_t = rel inside {10, 20, 27, 34, 38, 42, 46, 50};
            n_cmp++;
            if (tick !== exp_t) begin
                n_fail++;
                $display("FAIL %s_tick edge %0d: got %b want %b", tag, rel, tick, exp_t);
            end
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL %s_model edge %0d: got %h want %h", tag, rel, dut_vec(), model_vec());
            end
            if (rel == 20 || rel == 34 || rel == 42 || rel == 50) begin
                case (rel)
                    20:      want = {LVL_W'(1), PERIOD_W'(7), GAP_W'(7), 1'b0};
                    34:      want = {LVL_W'(2), PERIOD_W'(4), GAP_W'(9), 1'b0};
                    default: want = {LVL_W'(3), PERIOD_W'(4), GAP_W'(9), 1'b1};
                endcase
                n_cmp++;
                if ({level, period, min_empty, max_level} !== want) begin
                    n_fail++;
                    $display("FAIL %s_level edge %0d: got %h want %h", tag, rel,
                             {level, period, min_empty, max_level}, want);
                end
            end
        end
    endtask

    task automatic test_levels();
        run_schedule("levels");
        clear = 1;
        cycle();
        clear = 0;
    endtask

    task automatic test_pause();
        int t0, d;
        bit seen;
        start = 1; cycle(); start = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL pause_model edge %0d: got %h want %h", ec, dut_vec(), model_vec());
            end
            if (tick) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL pause_first_tick: got none want tick within 20 clocks");
        end
        t0 = ec;
        repeat (2) cycle();
        pause = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++;
            if (running !== 1'b0 || tick !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_hold edge %0d: got running=%b tick=%b want 0 0", ec, running, tick);
            end
        end
        pause = 0;
        seen = 0;
        d = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL pause_model edge %0d: got %h want %h", ec, dut_vec(), model_vec());
            end
            if (tick) begin
                seen = 1;
                d = ec - t0;
            end
        end
        n_cmp++;
        if (d != 15) begin
            n_fail++;
            $display("FAIL pause_gap: got %0d want 15", d);
        end
        clear = 1; cycle(); clear = 0;
    endtask

    task automatic test_clear();
        bit seen;
        int n_t;
        start = 1; cycle(); start = 0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cycle();
            if (level == LVL_W'(2)) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL clear_reach_l2: got level %0d want 2", level);
        end
        repeat (2) cycle();
        clear = 1;
        cycle();
        clear = 0;
        n_cmp++;
        if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL clear_outputs: got %h want %h", dut_vec(), RST_VEC);
        end
        n_t = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (tick) n_t++;
        end
        n_cmp++;
        if (n_t != 0) begin
            n_fail++;
            $display("FAIL clear_ticks_stop: got %0d want 0", n_t);
        end
        run_schedule("restart");
        clear = 1; cycle(); clear = 0;
    endtask

    task automatic test_async_reset();
        bit seen;
        start = 1; cycle(); start = 0;
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            cycle();
            if (tick === 1'b1 && level == LVL_W'(2)) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL arst_find_tick: got none want tick at level 2");
        end
        #2 rst = 1;
        #1;
        n_cmp++;
        if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL arst_immediate: got %h want %h", dut_vec(), RST_VEC);
        end
        #1 rst = 0;
        model_reset();
        cycle();
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL arst_after: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_same_cycle();
        int e0, rel, n_t;
        bit exp_t;
        // start + clear while idle: clear wins, stays idle.
        start = 1; clear = 1; cycle(); start = 0; clear = 0;
        n_t = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (tick || running) n_t++;
        end
        n_cmp++;
        if (n_t != 0 || dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL start_clear_idle: got active=%0d out=%h want 0 %h", n_t, dut_vec(), RST_VEC);
        end
        // pause + clear while running: back to idle.
        start = 1; cycle(); start = 0;
        repeat (3) cycle();
        pause = 1; clear = 1; cycle(); pause = 0; clear = 0;
        n_t = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (tick || running) n_t++;
        end
        n_cmp++;
        if (n_t != 0 || dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL pause_clear_run: got active=%0d out=%h want 0 %h", n_t, dut_vec(), RST_VEC);
        end
        // start while running must not disturb the tick phase.
        start = 1; cycle(); start = 0;
        e0 = ec;
        for (int i = 1; i <= 22; i++) begin
            start = (i >= 5 && i <= 7) || (i == 12);
            cycle();
            rel   = ec - e0;
            exp_t = (rel == 10 || rel == 20);
            n_cmp++;
            if (tick !== exp_t) begin
                n_fail++;
                $display("FAIL start_in_run edge %0d: got %b want %b", rel, tick, exp_t);
            end
        end
        start = 0;
        clear = 1; cycle(); clear = 0;
        // pause while idle is ignored and does not start a run.
        pause = 1;
        n_t = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (running) n_t++;
        end
        pause = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (tick || running) n_t++;
        end
        n_cmp++;
        if (n_t != 0 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL pause_idle: got active=%0d out=%h want 0 %h", n_t, dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            clear = ($urandom_range(0, 149) == 0);
            cycle();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random edge %0d: got %h want %h", ec, dut_vec(), model_vec());
            end
        end
        start = 0; pause = 0; clear = 0;
    endtask

    initial begin
        rst = 1; start = 0; pause = 0; clear = 0;
        model_reset();
        test_reset();
        test_levels();
        test_pause();
        test_clear();
        test_async_reset();
        test_same_cycle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
